// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised binary counter family.
package counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Clamp a parallel-load value to the terminal count.
  function automatic logic [MAX_WIDTH-1:0] sat_load(
    input logic [MAX_WIDTH-1:0] value,
    input logic [MAX_WIDTH-1:0] max
  );
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/param_binary_counter_if.sv
// Control/status bundle of param_binary_counter; master drives controls, slave is the counter.
interface param_binary_counter_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up_dn, clr, load, load_val, ovf_clr,
    input  count, wrap, ovf
  );

  modport slave (
    input  en, up_dn, clr, load, load_val, ovf_clr,
    output count, wrap, ovf
  );

endinterface

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each period.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_p0;

  assign tick = en && (pre_p0 == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_p0 <= '0;
    end else if (restart) begin
      pre_p0 <= '0;
    end else if (en) begin
      pre_p0 <= tick ? '0 : pre_p0 + PW'(1);
    end
  end

endmodule

// File: rtl/param_binary_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with clear, saturating load, wrap pulse and sticky overflow.
// Define COUNTER_PRESCALE_EN to step the count only every PRESCALE enabled cycles.
module param_binary_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int unsigned      PRESCALE = 4
) (
  input logic                  clk,
  input logic                  rst,
  param_binary_counter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("param_binary_counter: WIDTH out of range");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("param_binary_counter: MAX_VAL must be at least 1");
  end

  logic             step;
  logic [WIDTH-1:0] cnt_p0;
  logic             wrap_p0;
  logic             ovf_p0;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] load_sat;

`ifdef COUNTER_PRESCALE_EN
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("param_binary_counter: PRESCALE must be at least 2");
  end

  logic tick;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (bus.clr | bus.load),
    .tick    (tick)
  );

  assign step = tick;
`else
  // PRESCALE only matters when the prescaler is built in.
  localparam int unsigned unused_prescale = PRESCALE;

  assign step = bus.en;
`endif

  assign load_sat = WIDTH'(sat_load(MAX_WIDTH'(bus.load_val), MAX_WIDTH'(MAX_VAL)));

  always_comb begin
    cnt_nxt  = cnt_p0;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      cnt_nxt = '0;
    end else if (bus.load) begin
      cnt_nxt = load_sat;
    end else if (step) begin
      if (bus.up_dn == DIR_UP) begin
        if (cnt_p0 == MAX_VAL) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_p0 + WIDTH'(1);
        end
      end else begin
        if (cnt_p0 == '0) begin
          cnt_nxt  = MAX_VAL;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_p0 - WIDTH'(1);
        end
      end
    end
  end

  // Stage p0: registered count, wrap pulse and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0  <= '0;
      wrap_p0 <= 1'b0;
      ovf_p0  <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nxt;
      wrap_p0 <= wrap_nxt;
      if (wrap_nxt) begin
        ovf_p0 <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_p0 <= 1'b0;
      end
    end
  end

  assign bus.count = cnt_p0;
  assign bus.wrap  = wrap_p0;
  assign bus.ovf   = ovf_p0;

endmodule
